// File: rtl/reg_file_param_if.sv
// Bus bundle for reg_file_param: read ports, write port, PC port and scoreboard reservation.
// The controller side uses the master modport, the register file uses the slave modport.
interface reg_file_param_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic [ADDR_W-1:0] rd_addr1;
  logic [DATA_W-1:0] rd_data1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data2;
  logic              busy1;
  logic              busy2;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              pc_we;
  logic [DATA_W-1:0] pc_in;
  logic [DATA_W-1:0] pc_out;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;
  logic              rsv_err;

  modport master (
    output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, pc_we, pc_in, rsv_en, rsv_addr,
    input  rd_data1, rd_data2, busy1, busy2, pc_out, rsv_err
  );

  modport slave (
    input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, pc_we, pc_in, rsv_en, rsv_addr,
    output rd_data1, rd_data2, busy1, busy2, pc_out, rsv_err
  );
endinterface

// File: rtl/reg_file_param.sv
// Parametrised register file: two async reads, one sync write, PC alias port and busy scoreboard.
// Optional macro WRITE_BYPASS_EN forwards same-cycle write data (and busy clear) onto the read outputs.
module reg_file_param #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int PC_IDX = (2**ADDR_W) - 1
) (
  input  logic              clk,
  input  logic              reset,
  reg_file_param_if.slave   bus
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_IDX);

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic              r_rsv_err;

  logic [DEPTH-1:0]  w_busy_nxt;
  logic              w_rsv_err_set;
  logic              w_pc_wr;

  // Reserve is applied after the write-clear so a same-address pair leaves the bit set.
  always_comb begin
    w_busy_nxt = r_busy;
    if (bus.wr_en)  w_busy_nxt[bus.wr_addr]  = 1'b0;
    if (bus.rsv_en) w_busy_nxt[bus.rsv_addr] = 1'b1;
  end

  assign w_rsv_err_set = bus.rsv_en && r_busy[bus.rsv_addr] &&
                         !(bus.wr_en && (bus.wr_addr == bus.rsv_addr));
  assign w_pc_wr       = bus.pc_we && !(bus.wr_en && (bus.wr_addr == PC_ADDR));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
      r_busy    <= '0;
      r_rsv_err <= 1'b0;
    end else begin
      if (bus.wr_en) r_regs[bus.wr_addr] <= bus.wr_data;
      if (w_pc_wr)   r_regs[PC_ADDR]     <= bus.pc_in;
      r_busy <= w_busy_nxt;
      if (w_rsv_err_set) r_rsv_err <= 1'b1;
    end
  end

  logic [DATA_W-1:0] w_rd_data1;
  logic [DATA_W-1:0] w_rd_data2;
  logic [DATA_W-1:0] w_pc_out;
  logic              w_busy1;
  logic              w_busy2;

`ifdef WRITE_BYPASS_EN
  logic w_hit1;
  logic w_hit2;
  assign w_hit1 = bus.wr_en && (bus.wr_addr == bus.rd_addr1);
  assign w_hit2 = bus.wr_en && (bus.wr_addr == bus.rd_addr2);

  // A bypassed address has just been written, so it is free unless re-reserved this cycle.
  assign w_rd_data1 = w_hit1 ? bus.wr_data : r_regs[bus.rd_addr1];
  assign w_rd_data2 = w_hit2 ? bus.wr_data : r_regs[bus.rd_addr2];
  assign w_busy1    = w_hit1 ? (bus.rsv_en && (bus.rsv_addr == bus.rd_addr1)) : r_busy[bus.rd_addr1];
  assign w_busy2    = w_hit2 ? (bus.rsv_en && (bus.rsv_addr == bus.rd_addr2)) : r_busy[bus.rd_addr2];

  always_comb begin
    w_pc_out = r_regs[PC_ADDR];
    if (bus.wr_en && (bus.wr_addr == PC_ADDR)) w_pc_out = bus.wr_data;
    else if (bus.pc_we)                        w_pc_out = bus.pc_in;
  end
`else
  assign w_rd_data1 = r_regs[bus.rd_addr1];
  assign w_rd_data2 = r_regs[bus.rd_addr2];
  assign w_busy1    = r_busy[bus.rd_addr1];
  assign w_busy2    = r_busy[bus.rd_addr2];
  assign w_pc_out   = r_regs[PC_ADDR];
`endif

  assign bus.rd_data1 = w_rd_data1;
  assign bus.rd_data2 = w_rd_data2;
  assign bus.busy1    = w_busy1;
  assign bus.busy2    = w_busy2;
  assign bus.pc_out   = w_pc_out;
  assign bus.rsv_err  = r_rsv_err;
endmodule
